// File: rtl/ahb_sram_bridge.sv
// Zero-wait AHB-Lite slave in front of a 256x32 single-port SRAM, with a one-entry
// posted-write buffer and read forwarding. Define AHB_SRAM_ALIGN_ERR_EN to ERROR misaligned transfers.
module ahb_sram_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata,
  output logic [7:0]  ram_addr,
  output logic [31:0] ram_din,
  output logic [3:0]  ram_ben,
  output logic        ram_wren,
  input  logic [31:0] ram_dout
);

  // Handshake: a transfer is accepted when hsel & htrans[1] & hready; its data phase is the
  // following cycle, which this slave always completes at once (hreadyout=1) except in an ERROR.
  logic       acc, mis, rd_ap, wr_dp, rd_dp, fill, drain, fwd_hit;
  logic [3:0] ap_mask;
  logic       dp_valid, dp_write;
  logic [7:0] dp_waddr;
  logic [3:0] dp_mask;
  logic        buf_valid;
  logic [7:0]  buf_addr;
  logic [3:0]  buf_ben;
  logic [31:0] buf_data;
  logic        unused_haddr;

  assign unused_haddr = ^haddr[31:10];

`ifdef AHB_SRAM_ALIGN_ERR_EN
  typedef enum logic [1:0] {ERR_IDLE, ERR_WAIT, ERR_RESP} err_state_t;
  err_state_t err_state, err_next;

  assign mis = (hsize > 3'd2) | ((hsize == 3'd2) & (|haddr[1:0])) | ((hsize == 3'd1) & haddr[0]);
  assign acc = hsel & htrans[1] & hready & (err_state != ERR_WAIT) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) err_state <= ERR_IDLE;
    else     err_state <= err_next;
  end

  always_comb begin
    err_next  = err_state;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (err_state)
      ERR_IDLE: if (acc & mis) err_next = ERR_WAIT;
      ERR_WAIT: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        err_next  = ERR_RESP;
      end
      ERR_RESP: begin
        hresp    = 1'b1;
        err_next = (acc & mis) ? ERR_WAIT : ERR_IDLE;
      end
      default: err_next = ERR_IDLE;
    endcase
    if (rst) begin
      hreadyout = 1'b1;
      hresp     = 1'b0;
    end
  end
`else
  assign mis       = 1'b0;
  assign acc       = hsel & htrans[1] & hready & ~rst;
  assign hreadyout = 1'b1;
  assign hresp     = 1'b0;
`endif

  // Misaligned low bits are ignored: the lane is picked from the aligned position; hsize>2 acts as word.
  always_comb begin
    case (hsize)
      3'd0:    ap_mask = 4'b0001 << haddr[1:0];
      3'd1:    ap_mask = haddr[1] ? 4'b1100 : 4'b0011;
      default: ap_mask = 4'b1111;
    endcase
  end

  assign rd_ap   = acc & ~hwrite & ~mis;
  assign wr_dp   = dp_valid & dp_write;
  assign rd_dp   = dp_valid & ~dp_write;
  assign fwd_hit = buf_valid & (buf_addr == dp_waddr);

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_waddr <= '0;
      dp_mask  <= '0;
    end else if (hready) begin
      dp_valid <= acc & ~mis;
      dp_write <= hwrite;
      dp_waddr <= haddr[9:2];
      dp_mask  <= ap_mask;
    end
  end

  // Port arbitration: read address phase, then direct write, then buffer drain.
  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_ben  = '0;
    ram_wren = 1'b0;
    fill     = 1'b0;
    drain    = 1'b0;
    if (!rst) begin
      if (rd_ap) begin
        ram_addr = haddr[9:2];
        ram_ben  = 4'b1111;
        fill     = wr_dp;
      end else if (wr_dp) begin
        ram_addr = dp_waddr;
        ram_din  = hwdata;
        ram_ben  = dp_mask;
        ram_wren = 1'b1;
      end else if (buf_valid) begin
        ram_addr = buf_addr;
        ram_din  = buf_data;
        ram_ben  = buf_ben;
        ram_wren = 1'b1;
        drain    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_ben   <= '0;
      buf_data  <= '0;
    end else if (fill) begin
      buf_valid <= 1'b1;
      buf_addr  <= dp_waddr;
      buf_ben   <= dp_mask;
      buf_data  <= hwdata;
    end else if (drain) begin
      buf_valid <= 1'b0;
    end
  end

  always_comb begin
    hrdata = '0;
    if (!rst && rd_dp) begin
      for (int i = 0; i < 4; i++)
        hrdata[8*i +: 8] = (fwd_hit && buf_ben[i]) ? buf_data[8*i +: 8] : ram_dout[8*i +: 8];
    end
  end

  // The buffer is always drained before the next write data phase can arrive.
  a_no_write_over_buffer: assert property (@(posedge clk) disable iff (rst) !(wr_dp && buf_valid));

endmodule
